// File: rtl/elastic_pipe_reg_pkg.sv
// elastic_pipe_reg_pkg
// Shared configuration for the elastic pipeline register.
//
// Optional feature macro: ELASTIC_PIPE_SKID_EN
//   defined   -> a 1-entry skid buffer sits in front of slot 0. in_ready is
//                then a register output, and capacity grows by one.
//   undefined -> purely combinational ready chain, capacity = STAGES.
//
// Contents:
//   SKID_DEPTH     number of extra entries contributed by the skid buffer
//   pipe_capacity  total number of words the block can hold for a stage count
package elastic_pipe_reg_pkg;

`ifdef ELASTIC_PIPE_SKID_EN
  localparam int SKID_DEPTH = 1;
`else
  localparam int SKID_DEPTH = 0;
`endif

  function automatic int pipe_capacity(input int stages);
    return stages + SKID_DEPTH;
  endfunction

endpackage

// File: rtl/elastic_pipe_reg_stage.sv
// elastic_pipe_reg_stage
// One valid+data slot of the elastic pipeline. The same slot is reused as the
// optional skid buffer.
//
// Ports:
//   clk         rising-edge clock
//   reset       synchronous active-high reset (valid=0, data=RESET_VALUE)
//   flush       clear slot (valid=0, data=CLR_VALUE); lower priority than reset
//   load        slot takes in_valid this edge (in_data only when in_valid=1)
//   in_valid    valid bit offered by the predecessor
//   in_data     data offered by the predecessor
//   valid       registered valid bit
//   data        registered data
//   valid_next  valid bit the slot will hold after the next edge (no reset)
module elastic_pipe_reg_stage
  import elastic_pipe_reg_pkg::*;
#(
  parameter int               WIDTH       = 32,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0,
  parameter logic [WIDTH-1:0] CLR_VALUE   = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             load,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             valid,
  output logic [WIDTH-1:0] data,
  output logic             valid_next
);

  logic             valid_reg;
  logic [WIDTH-1:0] data_reg;
  logic [WIDTH-1:0] data_next;

  always_comb begin
    valid_next = valid_reg;
    data_next  = data_reg;
    if (flush) begin
      valid_next = 1'b0;
      data_next  = CLR_VALUE;
    end else if (load) begin
      valid_next = in_valid;
      // Data is only captured with a real word so a bubble passing through
      // does not disturb what the slot last presented.
      if (in_valid) begin
        data_next = in_data;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      valid_reg <= 1'b0;
      data_reg  <= RESET_VALUE;
    end else begin
      valid_reg <= valid_next;
      data_reg  <= data_next;
    end
  end

  assign valid = valid_reg;
  assign data  = data_reg;

endmodule

// File: rtl/elastic_pipe_reg.sv
// elastic_pipe_reg
// STAGES-deep chain of WIDTH-bit slots with valid/ready handshakes on both
// sides, per-slot bubble collapsing, flush and a registered occupancy count.
//
// Optional feature macro: ELASTIC_PIPE_SKID_EN (1-entry skid buffer before
// slot 0, registered in_ready, CAP = STAGES+1). Default: CAP = STAGES.
//
// Ports:
//   clk        rising-edge clock
//   reset      synchronous active-high reset (highest priority)
//   flush      discard all contents at the clock edge
//   in_valid   upstream has data
//   in_ready   block accepts in_data this cycle
//   in_data    upstream data
//   out_valid  last slot holds valid data
//   out_ready  downstream accepts out_data
//   out_data   data of the last slot (driven regardless of out_valid)
//   count      number of valid entries, registered
module elastic_pipe_reg
  import elastic_pipe_reg_pkg::*;
#(
  parameter int               WIDTH       = 32,
  parameter int               STAGES      = 2,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0,
  parameter logic [WIDTH-1:0] CLR_VALUE   = '0,
  localparam int              CAP         = pipe_capacity(STAGES),
  localparam int              CNT_W       = $clog2(CAP + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [CNT_W-1:0] count
);

  logic [STAGES-1:0] v;
  logic [STAGES-1:0] v_next;
  logic [STAGES-1:0] rdy;
  logic [STAGES-1:0] src_valid;
  logic [WIDTH-1:0]  d        [STAGES];
  logic [WIDTH-1:0]  src_data [STAGES];
  logic [CAP-1:0]    occ_next;
  logic [CNT_W-1:0]  count_reg;
  logic [CNT_W-1:0]  count_next;

  // Ready chain: a slot can take a word if it is empty (bubble collapse) or
  // if its own content is moving on this cycle.
  assign rdy[STAGES-1] = ~v[STAGES-1] | out_ready;

  generate
    for (genvar gi = 0; gi < STAGES - 1; gi++) begin : g_rdy
      assign rdy[gi] = ~v[gi] | rdy[gi+1];
    end

    for (genvar gi = 1; gi < STAGES; gi++) begin : g_src
      assign src_valid[gi] = v[gi-1];
      assign src_data[gi]  = d[gi-1];
    end

    for (genvar gi = 0; gi < STAGES; gi++) begin : g_slot
      elastic_pipe_reg_stage #(
        .WIDTH       (WIDTH),
        .RESET_VALUE (RESET_VALUE),
        .CLR_VALUE   (CLR_VALUE)
      ) u_slot (
        .clk        (clk),
        .reset      (reset),
        .flush      (flush),
        .load       (rdy[gi]),
        .in_valid   (src_valid[gi]),
        .in_data    (src_data[gi]),
        .valid      (v[gi]),
        .data       (d[gi]),
        .valid_next (v_next[gi])
      );
    end
  endgenerate

`ifdef ELASTIC_PIPE_SKID_EN
  logic             skid_v;
  logic             skid_v_next;
  logic [WIDTH-1:0] skid_d;
  logic             skid_load;
  logic             skid_in_valid;

  // in_ready depends only on the skid register (and flush), never on
  // out_ready, which breaks the long combinational ready path.
  assign in_ready = ~skid_v & ~flush;

  // A full skid updates only when slot 0 can drain it (loading a bubble
  // empties it). An empty skid captures the incoming word only when slot 0
  // is blocked; otherwise the word goes straight into slot 0.
  assign skid_load     = skid_v ? rdy[0] : ~rdy[0];
  assign skid_in_valid = in_valid & ~skid_v;

  elastic_pipe_reg_stage #(
    .WIDTH       (WIDTH),
    .RESET_VALUE (RESET_VALUE),
    .CLR_VALUE   (CLR_VALUE)
  ) u_skid (
    .clk        (clk),
    .reset      (reset),
    .flush      (flush),
    .load       (skid_load),
    .in_valid   (skid_in_valid),
    .in_data    (in_data),
    .valid      (skid_v),
    .data       (skid_d),
    .valid_next (skid_v_next)
  );

  // The parked word is older than anything at the input, so it goes first.
  assign src_valid[0] = skid_v | in_valid;
  assign src_data[0]  = skid_v ? skid_d : in_data;
  assign occ_next     = {skid_v_next, v_next};
`else
  assign in_ready     = rdy[0] & ~flush;
  assign src_valid[0] = in_valid;
  assign src_data[0]  = in_data;
  assign occ_next     = v_next;
`endif

  always_comb begin
    count_next = '0;
    for (int i = 0; i < CAP; i++) begin
      count_next = count_next + CNT_W'(occ_next[i]);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count_reg <= '0;
    end else begin
      count_reg <= count_next;
    end
  end

  assign count     = count_reg;
  assign out_valid = v[STAGES-1];
  assign out_data  = d[STAGES-1];

endmodule

// File: tb/tb_elastic_pipe_reg.sv
// tb_elastic_pipe_reg
// Directed self-checking bench for elastic_pipe_reg (WIDTH=8, STAGES=2,
// RESET_VALUE=0x00, CLR_VALUE=0x0F). Skid-specific steps are enabled by
// ELASTIC_PIPE_SKID_EN.
module tb_elastic_pipe_reg;

  localparam int WIDTH  = 8;
  localparam int STAGES = 2;
  localparam logic [WIDTH-1:0] RST_V = 8'h00;
  localparam logic [WIDTH-1:0] CLR_V = 8'h0F;
`ifdef ELASTIC_PIPE_SKID_EN
  localparam logic SKID = 1'b1;
`else
  localparam logic SKID = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             reset;
  logic             flush;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic [1:0]       count;

  int tests_run = 0;
  int tests_failed = 0;

  elastic_pipe_reg #(
    .WIDTH       (WIDTH),
    .STAGES      (STAGES),
    .RESET_VALUE (RST_V),
    .CLR_VALUE   (CLR_V)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .count     (count)
  );

  always #5 clk = ~clk;

  // Advance one edge and sample 1 time unit later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    assert (obs === exp) begin
      $display("[TB] check %s: got %0h expected %0h ok", tag, obs, exp);
    end else begin
      tests_failed++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, obs, exp);
      $error("check %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    reset = 1'b1; flush = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;

    // ---- Reset ----
    tick(); tick();
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_data",  32'(out_data),  32'(RST_V));
    check("rst_count",     32'(count),     32'd0);
    reset = 1'b0; #1;
    check("rst_in_ready",  32'(in_ready),  32'd1);

    // ---- Flow: 11,22,33 back to back ----
    out_ready = 1'b1;
    in_valid = 1'b1; in_data = 8'h11; tick();
    check("flow_e1_valid", 32'(out_valid), 32'd0);
    check("flow_e1_count", 32'(count),     32'd1);
    in_data = 8'h22; tick();
    check("flow_e2_valid", 32'(out_valid), 32'd1);
    check("flow_e2_data",  32'(out_data),  32'h11);
    check("flow_e2_count", 32'(count),     32'd2);
    in_data = 8'h33; tick();
    check("flow_e3_data",  32'(out_data),  32'h22);
    check("flow_e3_count", 32'(count),     32'd2);
    in_valid = 1'b0; tick();
    check("flow_e4_data",  32'(out_data),  32'h33);
    check("flow_e4_count", 32'(count),     32'd1);
    tick();
    check("flow_e5_valid", 32'(out_valid), 32'd0);
    check("flow_e5_count", 32'(count),     32'd0);

    // ---- Backpressure: A,B with out_ready=0 ----
    out_ready = 1'b0;
    in_valid = 1'b1; in_data = 8'h0A; tick();
    in_data = 8'h0B; tick();
    in_valid = 1'b0; #1;
    check("bp_full_count",    32'(count),     32'd2);
    check("bp_full_in_ready", 32'(in_ready),  32'(SKID));
    check("bp_full_data",     32'(out_data),  32'h0A);
    tick();
    check("bp_hold_valid",    32'(out_valid), 32'd1);
    check("bp_hold_data",     32'(out_data),  32'h0A);
    check("bp_hold_count",    32'(count),     32'd2);
    // Full pass-through: out_ready=1 lets C in during the same cycle.
    out_ready = 1'b1; in_valid = 1'b1; in_data = 8'h0C; #1;
    check("bp_pass_in_ready", 32'(in_ready),  32'd1);
    tick();
    check("bp_rel_data_b",    32'(out_data),  32'h0B);
    check("bp_rel_count",     32'(count),     32'd2);
    in_valid = 1'b0; tick();
    check("bp_rel_data_c",    32'(out_data),  32'h0C);
    check("bp_rel_count2",    32'(count),     32'd1);
    tick();
    check("bp_empty_count",   32'(count),     32'd0);

    // ---- Bubble collapse: 5, idle, 6 with out_ready=0 ----
    out_ready = 1'b0;
    in_valid = 1'b1; in_data = 8'h05; tick();
    in_valid = 1'b0; tick();
    check("bub_one_count", 32'(count),    32'd1);
    check("bub_one_data",  32'(out_data), 32'h05);
    in_valid = 1'b1; in_data = 8'h06; tick();
    in_valid = 1'b0; tick();
    check("bub_two_count", 32'(count),    32'd2);
    check("bub_two_data",  32'(out_data), 32'h05);
    out_ready = 1'b1; tick();
    check("bub_next_valid", 32'(out_valid), 32'd1);
    check("bub_next_data",  32'(out_data),  32'h06);
    tick();
    check("bub_empty_count", 32'(count), 32'd0);

    // ---- Flush with a word offered ----
    out_ready = 1'b0;
    in_valid = 1'b1; in_data = 8'h01; tick();
    in_data = 8'h02; tick();
    check("fl_pre_count", 32'(count), 32'd2);
    flush = 1'b1; in_data = 8'h77; #1;
    check("fl_in_ready",  32'(in_ready), 32'd0);
    tick();
    flush = 1'b0; in_valid = 1'b0;
    check("fl_out_valid", 32'(out_valid), 32'd0);
    check("fl_count",     32'(count),     32'd0);
    check("fl_out_data",  32'(out_data),  32'(CLR_V));
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("fl_no_77", 32'(out_valid), 32'd0);
    end

    // ---- Reset has priority over flush ----
    in_valid = 1'b1; in_data = 8'h44; out_ready = 1'b0; tick();
    in_valid = 1'b0;
    reset = 1'b1; flush = 1'b1; tick();
    check("prio_out_data", 32'(out_data), 32'(RST_V));
    check("prio_count",    32'(count),    32'd0);
    reset = 1'b0; flush = 1'b0; tick();

`ifdef ELASTIC_PIPE_SKID_EN
    // ---- Skid: third word parks while the pipe is full ----
    out_ready = 1'b0;
    in_valid = 1'b1; in_data = 8'h0A; tick();
    in_data = 8'h0B; tick();
    in_data = 8'h09; #1;
    check("skid_in_ready_now", 32'(in_ready), 32'd1);
    tick();
    in_valid = 1'b0;
    check("skid_in_ready_next", 32'(in_ready), 32'd0);
    check("skid_count",         32'(count),    32'd3);
    check("skid_head",          32'(out_data), 32'h0A);
    out_ready = 1'b1; tick();
    check("skid_out_b",   32'(out_data), 32'h0B);
    check("skid_count_2", 32'(count),    32'd2);
    tick();
    check("skid_out_9",   32'(out_data), 32'h09);
    check("skid_valid_9", 32'(out_valid), 32'd1);
    tick();
    check("skid_empty",   32'(count), 32'd0);
`endif

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
